// File: rtl/axi_rd_pkg.sv
// Shared types and encodings for the AXI burst read master and its helpers.
package axi_rd_pkg;

  // Burst type encodings
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Response encodings; numeric order doubles as severity order
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Field widths of the latched command; the master's ADDR_W/LEN_W/SIZE_W
  // must not exceed these.
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_LEN_W  = 8;
  localparam int AXI_SIZE_W = 3;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_LEN_W-1:0]  len;
    logic [AXI_SIZE_W-1:0] size;
    logic [1:0]            burst;
    logic [3:0]            cache;
  } cmd_t;

endpackage

// File: rtl/axi_beat_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts.
module axi_beat_addr_gen
  import axi_rd_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8,
  parameter int SIZE_W = 3
) (
  input  logic [ADDR_W-1:0] cur_addr,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [SIZE_W-1:0] size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] bytes;
  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] win;
  logic [ADDR_W-1:0] lower;

  // Step the beat address; WRAP folds back to the window base at its end
  always_comb begin
    bytes = ADDR_W'(1) << size;
    incr  = (cur_addr & ~(bytes - ADDR_W'(1))) + bytes;
    win   = (ADDR_W'(len) + ADDR_W'(1)) << size;
    lower = cur_addr & ~(win - ADDR_W'(1));
    case (burst)
      BURST_FIXED: next_addr = start_addr;
      BURST_INCR:  next_addr = incr;
      BURST_WRAP:  next_addr = (incr == lower + win) ? lower : incr;
      default:     next_addr = cur_addr;
    endcase
  end

endmodule

// File: rtl/axi_master_rd_burst.sv
// AXI read master: one burst at a time, beats forwarded with their address.
module axi_master_rd_burst
  import axi_rd_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8,
  parameter int SIZE_W = 3
) (
  input  logic              aclk,
  input  logic              areset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [SIZE_W-1:0] cmd_size,
  input  logic [1:0]        cmd_burst,
  input  logic [3:0]        cmd_cache,
  output logic              ar_valid,
  input  logic              ar_ready,
  output logic [ADDR_W-1:0] ar_addr,
  output logic [LEN_W-1:0]  ar_len,
  output logic [SIZE_W-1:0] ar_size,
  output logic [1:0]        ar_burst,
  output logic [3:0]        ar_cache,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [DATA_W-1:0] r_data,
  input  logic [1:0]        r_resp,
  input  logic              r_last,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [1:0]        rd_resp,
  output logic              rd_last,
  output logic              done_valid,
  output logic [1:0]        done_resp,
  output logic              done_err_illegal,
  output logic              done_err_last,
  output logic              busy
);

  localparam int MAX_SIZE = $clog2(DATA_W / 8);

  state_t            state, state_nxt;
  cmd_t              cmd_q;
  logic [ADDR_W-1:0] beat_addr, next_addr;
  logic [LEN_W-1:0]  beat_cnt;
  logic              accept, illegal, r_hs, last_cnt, burst_end;

  // Commands that must never reach the bus
  function automatic logic cmd_illegal(input logic [ADDR_W-1:0] addr,
                                       input logic [LEN_W-1:0]  len,
                                       input logic [SIZE_W-1:0] size,
                                       input logic [1:0]        burst);
    logic [23:0] off, span;
    logic        bad;
    off  = 24'(addr[11:0]) & ~((24'd1 << size) - 24'd1);
    span = (24'(len) + 24'd1) << size;
    bad  = 1'b0;
    if (burst == 2'b11) bad = 1'b1;
    if (int'(size) > MAX_SIZE) bad = 1'b1;
    if (burst == BURST_WRAP) begin
      if (!(len inside {LEN_W'(1), LEN_W'(3), LEN_W'(7), LEN_W'(15)})) bad = 1'b1;
      if ((addr & ((ADDR_W'(1) << size) - ADDR_W'(1))) != '0) bad = 1'b1;
    end
    // Last byte of an INCR burst must stay in the start 4 KB page
    if (burst == BURST_INCR && ((off + span - 24'd1) >> 12) != 24'd0) bad = 1'b1;
    return bad;
  endfunction

  assign accept    = cmd_valid && cmd_ready;
  assign illegal   = cmd_illegal(cmd_addr, cmd_len, cmd_size, cmd_burst);
  assign r_ready   = (state == DATA) && (!rd_valid || rd_ready);
  assign r_hs      = r_valid && r_ready;
  assign last_cnt  = (beat_cnt == cmd_q.len[LEN_W-1:0]);
  assign burst_end = r_hs && (last_cnt || r_last);
  assign busy      = (state != IDLE);

  assign ar_addr  = cmd_q.addr[ADDR_W-1:0];
  assign ar_len   = cmd_q.len[LEN_W-1:0];
  assign ar_size  = cmd_q.size[SIZE_W-1:0];
  assign ar_burst = cmd_q.burst;
  assign ar_cache = cmd_q.cache;

  axi_beat_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W),
    .SIZE_W (SIZE_W)
  ) u_addr_gen (
    .cur_addr   (beat_addr),
    .start_addr (cmd_q.addr[ADDR_W-1:0]),
    .len        (cmd_q.len[LEN_W-1:0]),
    .size       (cmd_q.size[SIZE_W-1:0]),
    .burst      (cmd_q.burst),
    .next_addr  (next_addr)
  );

  // State register; cmd_ready is registered so it stays low through reset
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd_ready <= (state_nxt == IDLE);
    end
  end

  // Next-state and per-state handshake outputs
  always_comb begin
    state_nxt  = state;
    ar_valid   = 1'b0;
    done_valid = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = illegal ? DONE : ADDR;
      ADDR: begin
        ar_valid = 1'b1;
        if (ar_ready) state_nxt = DATA;
      end
      DATA: if (burst_end) state_nxt = DONE;
      DONE: begin
        done_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, beat tracking and completion status
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      cmd_q            <= '0;
      beat_addr        <= '0;
      beat_cnt         <= '0;
      done_resp        <= RESP_OKAY;
      done_err_illegal <= 1'b0;
      done_err_last    <= 1'b0;
    end else if (accept) begin
      cmd_q            <= '{addr: AXI_ADDR_W'(cmd_addr), len: AXI_LEN_W'(cmd_len),
                            size: AXI_SIZE_W'(cmd_size), burst: cmd_burst, cache: cmd_cache};
      beat_addr        <= cmd_addr;
      beat_cnt         <= '0;
      done_resp        <= RESP_OKAY;
      done_err_illegal <= illegal;
      done_err_last    <= 1'b0;
    end else if (r_hs) begin
      beat_addr <= next_addr;
      beat_cnt  <= beat_cnt + LEN_W'(1);
      if (r_resp > done_resp) done_resp <= r_resp;
      // Ending beat disagreeing with r_last: either early or missing last
      if (burst_end) done_err_last <= last_cnt ^ r_last;
    end
  end

  // Stage boundary: R beat -> single-entry output register
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_addr  <= '0;
      rd_resp  <= RESP_OKAY;
      rd_last  <= 1'b0;
    end else if (r_hs) begin
      rd_valid <= 1'b1;
      rd_data  <= r_data;
      rd_addr  <= beat_addr;
      rd_resp  <= r_resp;
      rd_last  <= burst_end;
    end else if (rd_ready) begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_master_rd_burst.sv
// Randomized bench for axi_master_rd_burst against a spec-level burst model.
module tb_axi_master_rd_burst;
  import axi_rd_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;
  localparam int SIZE_W = 3;

  logic              aclk = 1'b0;
  logic              areset_n = 1'b0;
  logic              cmd_valid = 1'b0, cmd_ready;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [SIZE_W-1:0] cmd_size = '0;
  logic [1:0]        cmd_burst = '0;
  logic [3:0]        cmd_cache = '0;
  logic              ar_valid, ar_ready = 1'b0;
  logic [ADDR_W-1:0] ar_addr;
  logic [LEN_W-1:0]  ar_len;
  logic [SIZE_W-1:0] ar_size;
  logic [1:0]        ar_burst;
  logic [3:0]        ar_cache;
  logic              r_valid = 1'b0, r_ready;
  logic [DATA_W-1:0] r_data = '0;
  logic [1:0]        r_resp = '0;
  logic              r_last = 1'b0;
  logic              rd_valid, rd_ready = 1'b1;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        rd_resp;
  logic              rd_last;
  logic              done_valid;
  logic [1:0]        done_resp;
  logic              done_err_illegal, done_err_last, busy;

  int n_chk = 0;
  int n_pass = 0;

  always #5 aclk = ~aclk;

  axi_master_rd_burst #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .SIZE_W(SIZE_W)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_cache(cmd_cache),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
    .ar_size(ar_size), .ar_burst(ar_burst), .ar_cache(ar_cache),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_addr(rd_addr),
    .rd_resp(rd_resp), .rd_last(rd_last),
    .done_valid(done_valid), .done_resp(done_resp), .done_err_illegal(done_err_illegal),
    .done_err_last(done_err_last), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  // Address of beat i, straight from the burst-type definitions
  function automatic longint unsigned ref_addr(input longint unsigned start, input int len,
                                               input int size, input logic [1:0] burst, input int i);
    longint unsigned bytes, win, lower;
    bytes = longint'(1) << size;
    case (burst)
      BURST_INCR: return (i == 0) ? start : (start / bytes) * bytes + longint'(i) * bytes;
      BURST_WRAP: begin
        win   = longint'(len + 1) * bytes;
        lower = (start / win) * win;
        return lower + ((start - lower) + longint'(i) * bytes) % win;
      end
      default: return start;
    endcase
  endfunction

  function automatic bit ref_illegal(input longint unsigned addr, input int len,
                                     input int size, input logic [1:0] burst);
    longint unsigned bytes, last_byte;
    if (burst == 2'b11 || size > 2) return 1'b1;
    bytes = longint'(1) << size;
    if (burst == BURST_WRAP)
      return !(len == 1 || len == 3 || len == 7 || len == 15) || (addr % bytes != 0);
    if (burst == BURST_INCR) begin
      last_byte = (addr / bytes) * bytes + longint'(len + 1) * bytes - 1;
      return (last_byte / 4096) != (addr / 4096);
    end
    return 1'b0;
  endfunction

  // One command end to end: slave responder, output sink and checks in lockstep
  task automatic run_burst(input logic [31:0] addr, input int len, input int size,
                           input logic [1:0] burst, input logic [3:0] cache,
                           input int early, input bit no_last, input int err_at,
                           input int ar_hold, input int stall_at, input int stall_len,
                           input bit rnd, input int rst_at);
    bit ill, ar_done, r_pend, done_seen, prev_hs, prev_done, held;
    int n_send, sent, rcvd, cyc, last_hs, ar_wait, stall_cnt;
    logic [DATA_W-1:0] dq[$];
    logic [1:0] rq[$];
    logic [1:0] exp_resp;
    logic [DATA_W-1:0] h_data;
    logic [ADDR_W-1:0] h_addr;
    ill = ref_illegal(addr, len, size, burst);
    n_send = ill ? 0 : ((early >= 0) ? early + 1 : len + 1);
    exp_resp = RESP_OKAY;
    for (int i = 0; i < n_send; i++) begin
      dq.push_back($urandom);
      rq.push_back(rnd ? 2'($urandom % 4) : ((i == err_at) ? RESP_SLVERR : RESP_OKAY));
      if (rq[i] > exp_resp) exp_resp = rq[i];
    end

    @(negedge aclk);
    cmd_addr = addr; cmd_len = LEN_W'(len); cmd_size = SIZE_W'(size);
    cmd_burst = burst; cmd_cache = cache; cmd_valid = 1'b1;
    #1 chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    @(negedge aclk);
    cmd_valid = 1'b0;
    #1;
    if (ill) begin
      chk("ill_done_valid", 64'(done_valid), 64'd1);
      chk("ill_flag", 64'(done_err_illegal), 64'd1);
      chk("ill_no_ar", 64'(ar_valid), 64'd0);
      @(negedge aclk);
      #1;
      chk("ill_done_pulse", 64'(done_valid), 64'd0);
      chk("ill_no_ar2", 64'(ar_valid), 64'd0);
      chk("ill_cmd_ready", 64'(cmd_ready), 64'd1);
      return;
    end
    chk("ar_valid_latency", 64'(ar_valid), 64'd1);

    ar_done = 0; r_pend = 0; done_seen = 0; prev_hs = 0; prev_done = 0; held = 0;
    sent = 0; rcvd = 0; cyc = 0; last_hs = -10; ar_wait = ar_hold; stall_cnt = 0;
    h_data = '0; h_addr = '0;
    while (1) begin
      ar_ready = ar_valid && !ar_done && (ar_wait == 0);
      if (!r_pend) begin
        r_valid = 1'b0; r_last = 1'b0;
        if (ar_done && sent < n_send && (!rnd || $urandom % 3 != 0)) begin
          r_valid = 1'b1; r_data = dq[sent]; r_resp = rq[sent];
          r_last = (sent == early) || (sent == len && !no_last);
          r_pend = 1;
        end
      end
      if (stall_cnt > 0) begin
        rd_ready = 1'b0; stall_cnt--;
      end else begin
        rd_ready = rnd ? ($urandom % 4 != 0) : 1'b1;
      end
      #1;
      if (rst_at >= 0 && ar_done && sent == rst_at) begin
        areset_n = 1'b0;
        #1;
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("rst_r_ready", 64'(r_ready), 64'd0);
        chk("rst_ar_valid", 64'(ar_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_done_resp", 64'(done_resp), 64'd0);
        r_valid = 1'b0; ar_ready = 1'b0; rd_ready = 1'b1;
        @(negedge aclk);
        areset_n = 1'b1;
        @(negedge aclk);
        #1;
        chk("rst_exit_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_exit_busy", 64'(busy), 64'd0);
        return;
      end
      if (prev_done) begin
        chk("cmd_ready_after_done", 64'(cmd_ready), 64'd1);
        chk("busy_after_done", 64'(busy), 64'd0);
      end
      if (prev_hs) chk("rd_valid_latency", 64'(rd_valid), 64'd1);
      if (held) begin
        chk("hold_valid", 64'(rd_valid), 64'd1);
        chk("hold_data", 64'(rd_data), 64'(h_data));
        chk("hold_addr", 64'(rd_addr), 64'(h_addr));
      end
      if (ar_done) chk("ar_single", 64'(ar_valid), 64'd0);
      if (ar_valid) begin
        chk("ar_addr", 64'(ar_addr), 64'(addr));
        chk("ar_len", 64'(ar_len), 64'(len));
        chk("ar_size", 64'(ar_size), 64'(size));
        chk("ar_burst", 64'(ar_burst), 64'(burst));
        chk("ar_cache", 64'(ar_cache), 64'(cache));
      end
      if (rd_valid && !rd_ready) chk("r_ready_stall", 64'(r_ready), 64'd0);
      if (done_valid) begin
        chk("done_timing", 64'(cyc), 64'(last_hs + 1));
        chk("done_resp", 64'(done_resp), 64'(exp_resp));
        chk("done_err_last", 64'(done_err_last), 64'(early >= 0 || no_last));
        chk("done_err_illegal", 64'(done_err_illegal), 64'd0);
        done_seen = 1;
      end
      // Effects of the coming clock edge
      if (ar_valid && ar_ready) ar_done = 1;
      else if (ar_valid && ar_wait > 0) ar_wait--;
      prev_hs = r_valid && r_ready;
      if (prev_hs) begin
        sent++; r_pend = 0; last_hs = cyc;
      end
      if (rd_valid && rd_ready) begin
        if (rcvd < n_send) begin
          chk("rd_addr", 64'(rd_addr), 64'(ref_addr(addr, len, size, burst, rcvd) & 32'hFFFF_FFFF));
          chk("rd_data", 64'(rd_data), 64'(dq[rcvd]));
          chk("rd_resp", 64'(rd_resp), 64'(rq[rcvd]));
          chk("rd_last", 64'(rd_last), 64'(rcvd == n_send - 1));
          rcvd++;
          if (rcvd == stall_at) stall_cnt = stall_len;
        end else begin
          chk("rd_extra_beat", 64'(rcvd), 64'(n_send - 1));
        end
      end
      held = rd_valid && !rd_ready;
      h_data = rd_data; h_addr = rd_addr;
      prev_done = done_valid;
      cyc++;
      if (done_seen && rcvd == n_send && !prev_done) break;
      if (cyc > 600) begin
        chk("burst_timeout", 64'(cyc), 64'd0);
        break;
      end
      @(negedge aclk);
    end
    r_valid = 1'b0; r_last = 1'b0; ar_ready = 1'b0; rd_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge aclk);
    #1;
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("reset_rd_valid", 64'(rd_valid), 64'd0);
    chk("reset_done_valid", 64'(done_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    areset_n = 1'b1;
    @(negedge aclk);
    #1 chk("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);

    // addr, len, size, burst, cache, early, no_last, err_at, ar_hold, stall_at, stall_len, rnd, rst_at
    run_burst(32'h100, 3, 2, BURST_INCR,  4'h3, -1, 0, -1, 0, -1, 0, 0, -1);
    run_burst(32'h108, 3, 2, BURST_WRAP,  4'h0, -1, 0, -1, 0, -1, 0, 0, -1);
    run_burst(32'h040, 2, 2, BURST_FIXED, 4'h0, -1, 0, -1, 0,  1, 5, 0, -1);
    run_burst(32'h100, 2, 2, BURST_WRAP,  4'h0, -1, 0, -1, 0, -1, 0, 0, -1);
    run_burst(32'hFF8, 3, 2, BURST_INCR,  4'h0, -1, 0, -1, 0, -1, 0, 0, -1);
    run_burst(32'h100, 3, 2, 2'b11,       4'h0, -1, 0, -1, 0, -1, 0, 0, -1);
    run_burst(32'h200, 3, 2, BURST_INCR,  4'h0,  1, 0,  0, 0, -1, 0, 0, -1);
    run_burst(32'h300, 1, 2, BURST_INCR,  4'hA, -1, 0, -1, 10, -1, 0, 0, -1);
    run_burst(32'h500, 3, 2, BURST_INCR,  4'h0, -1, 1, -1, 0, -1, 0, 0, -1);
    run_burst(32'h400, 7, 2, BURST_INCR,  4'h0, -1, 0, -1, 0, -1, 0, 0, 3);
    run_burst(32'h0F0, 1, 1, BURST_WRAP,  4'h0, -1, 0, -1, 0, -1, 0, 0, -1);

    for (int t = 0; t < 40; t++) begin
      logic [1:0]  b;
      logic [31:0] a;
      int s, l, e;
      bit nl;
      b = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom % 3);
      s = ($urandom % 8 == 0) ? 3 : int'($urandom % 3);
      if (b == BURST_WRAP) begin
        case ($urandom % 5)
          0: l = 1;
          1: l = 3;
          2: l = 7;
          3: l = 15;
          default: l = 2;
        endcase
      end else begin
        l = int'($urandom % 16);
      end
      a = $urandom_range(0, 8191);
      if ($urandom % 4 != 0) a = a & ~((32'd1 << s) - 32'd1);
      e = (l > 0 && $urandom % 4 == 0) ? int'($urandom_range(0, l - 1)) : -1;
      nl = (e < 0) && ($urandom % 6 == 0);
      run_burst(a, l, s, b, 4'($urandom), e, nl, -1, int'($urandom % 4), -1, 0, 1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axi_master_rd_burst.md
# axi_master_rd_burst

Parametrised AXI read master that accepts one read command at a time from a local requester and issues it on the AR channel. It collects the R-channel beats and forwards each beat, tagged with its computed beat address, on a registered output stream. It supports FIXED, INCR and WRAP bursts, rejects illegal commands without issuing them, checks r_last against the beat count, and reports a per-burst completion status. It sits between a DMA or test-driver requester and the AXI interconnect, replacing the single-beat fixed-mode read master.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (8..1024, power of 2)
- LEN_W, 8, burst length field width (AXI4)
- SIZE_W, 3, size field width
- aclk  in  1  clock
- areset_n  in  1  asynchronous, active-low reset
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_addr, cmd_len, cmd_size  in  ADDR_W, LEN_W, SIZE_W  burst start address, beats−1, log2 bytes per beat
- cmd_burst, cmd_cache  in  2, 4  burst type, cache attributes
- ar_valid / ar_ready  out / in  1  AR handshake
- ar_addr, ar_len, ar_size, ar_burst, ar_cache  out  ADDR_W, LEN_W, SIZE_W, 2, 4  AR payload
- r_valid / r_ready  in / out  1  R handshake
- r_data, r_resp, r_last  in  DATA_W, 2, 1  R payload
- rd_valid / rd_ready  out / in  1  output beat handshake
- rd_data, rd_addr, rd_resp, rd_last  out  DATA_W, ADDR_W, 2, 1  output beat (rd_last is set on the final accepted beat)
- done_valid  out  1  one-cycle completion pulse
- done_resp  out  2  worst r_resp of the burst (numeric max)
- done_err_illegal, done_err_last  out  1  completion error flags
- busy  out  1  high whenever the block is not in IDLE

## Operation
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE: cmd_ready=1. On cmd_valid, the command is latched and checked.
  - Legal command: go to ADDR.
  - Illegal command: go to DONE with done_err_illegal=1; no AR is issued.
- Illegal commands:
  - cmd_burst=2'b11.
  - cmd_size > log2(DATA_W/8).
  - WRAP with cmd_len not in {1,3,7,15}.
  - WRAP with cmd_addr not aligned to 1<<size.
  - INCR whose last byte crosses a 4 KB boundary.
- ADDR: ar_valid=1 with the payload from the latched command. On ar_valid&&ar_ready, go to DATA.
- DATA:
  - r_ready = !rd_valid || rd_ready (single-entry output register, no bubbles).
  - Each R handshake loads rd_data, rd_resp and rd_addr (current beat address), then advances the beat counter and beat address.
- Beat address generation:
  - FIXED: the start address on every beat.
  - INCR: the first beat uses the start address; later beats use (previous beat address aligned to 1<<size) + (1<<size).
  - WRAP: wrap window = (len+1)<<size, with the lower bound aligned to the window; the address wraps to the lower bound at the window end.
- Burst termination:
  - Normal end: the handshake of beat len+1. done_err_last is set if r_last=0 on that beat.
  - Early end: r_last=1 on any earlier beat ends the burst at that beat and sets done_err_last.
  - In both cases the ending beat drives rd_last=1, then the FSM goes to DONE.
- done_resp accumulates max(r_resp) over the burst and is cleared on command accept.
- DONE: done_valid=1 for one cycle, then go to IDLE. The last output beat may still be held in the rd_* register when done_valid pulses.
- Reset values: all outputs 0 (cmd_ready=0 during reset, 1 in the first cycle after reset); FSM=IDLE.

## Timing
- Command accept in cycle N → ar_valid=1 in cycle N+1.
- ar_valid and the AR payload stay stable until ar_ready; ar_valid is never withdrawn.
- AR handshake in cycle M → r_ready may assert in cycle M+1.
- R handshake in cycle K → rd_valid=1 in cycle K+1. Latency is 1 cycle, and throughput is 1 beat per cycle while rd_ready=1.
- rd_valid and rd_* stay stable while rd_ready=0. With rd_valid=1 and rd_ready=0, r_ready=0.
- Final R handshake in cycle K → done_valid in cycle K+1 → cmd_ready in cycle K+2.
- Illegal command accepted in cycle N → done_valid in cycle N+1. No ar_valid is asserted at any point.
- Reset asserted mid-burst immediately clears all state and outputs. The outstanding AXI transaction is abandoned, and the slave must be reset together with this block.

## Structure
- Package axi_rd_pkg holds:
  - burst encodings FIXED=2'b00, INCR=2'b01, WRAP=2'b10;
  - resp constants OKAY/EXOKAY/SLVERR/DECERR;
  - the FSM state enum;
  - the command struct (addr, len, size, burst, cache).
- Sub-module axi_beat_addr_gen is purely combinational. It computes (cur_addr, start_addr, len, size, burst) → next_addr, and is reusable by a future write master.

## Test plan
- INCR, addr 0x100, len 3, size 2 → one AR (len 3). rd_addr sequence 0x100, 0x104, 0x108, 0x10C; rd_last on the 4th beat; done_resp=0; no error flags.
- WRAP, addr 0x108, len 3, size 2 → rd_addr sequence 0x108, 0x10C, 0x100, 0x104.
- FIXED, addr 0x40, len 2, with rd_ready low for 5 cycles after beat 1 → r_ready low during the stall. All three beats are delivered in order, each with rd_addr 0x40, and no data is lost.
- Illegal commands → done_valid one cycle after accept, done_err_illegal=1, ar_valid never asserted:
  - WRAP, len 2;
  - INCR, addr 0xFF8, len 3, size 2 (crosses 4 KB);
  - burst 2'b11.
- INCR, len 3, with r_last=1 on beat 2 and r_resp=SLVERR on beat 1 → burst ends after 2 beats with rd_last on beat 2; done_err_last=1; done_resp=2'b10.
- ar_ready held low for 10 cycles → AR payload stable throughout.
- areset_n asserted mid-DATA → all outputs 0 and FSM returns to IDLE.
